lsu_mem_stage: RTL

- Load/store unit for the Memory stage.
- Sits between the M-stage pipeline register (upstream valid/ready) and the W-stage pipeline register (downstream valid/ready).
- Replaces the zero-latency combinational data memory with a multi-cycle request/response memory port.
- Handles byte-lane alignment, load sign/zero extension, misalignment detection and response timeout.

---
 rtl/lsu_mem_stage_if.sv | 50 +++++
 rtl/lsu_mem_stage.sv | 136 +++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage_if.sv
// Bundled M-stage handshake, memory request/response port and W-stage result port.
// slave = LSU side, master = surrounding pipeline and memory.
interface lsu_mem_stage_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              s_valid;
   logic              s_ready;
   logic              mvalid;
   logic              mwen;
   logic [7:0]        mwmask;
   logic [2:0]        mrtype;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;

   logic              req_valid;
   logic              req_ready;
   logic              req_wen;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [3:0]        req_wstrb;

   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   logic              m_valid;
   logic              m_ready;
   logic [31:0]       m_rdata;
   logic              m_err;

   modport slave (
      input  s_valid, mvalid, mwen, mwmask, mrtype, addr, wdata,
      output s_ready,
      output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      output m_valid, m_rdata, m_err,
      input  m_ready
   );

   modport master (
      output s_valid, mvalid, mwen, mwmask, mrtype, addr, wdata,
      input  s_ready,
      input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      input  m_valid, m_rdata, m_err,
      output m_ready
   );
endinterface

// File: rtl/lsu_mem_stage.sv
// M-stage load/store unit: one op at a time over a request/response memory port,
// with lane shifting, load extension, misalignment trap and response timeout.
module lsu_mem_stage #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic           clk,
   input  logic           rst,
   lsu_mem_stage_if.slave bus
);
   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic              wen_q;
   logic [2:0]        rtype_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;
   logic [1:0]        off_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       rdata_q;
   logic              err_q;

   logic [1:0]        off_d;
   logic [31:0]       wdata_d;
   logic [3:0]        wstrb_d;
   logic              half_d;
   logic              word_d;
   logic              mis_d;
   logic [31:0]       ld_shift;
   logic [31:0]       ld_ext;
   logic [CNT_W-1:0]  cnt_d;
   logic              hs;
   logic              unused_mwmask_hi;

   assign unused_mwmask_hi = ^bus.mwmask[7:4];

   always_comb begin
      off_d   = bus.addr[1:0];
      wdata_d = bus.wdata << {off_d, 3'b000};
      wstrb_d = bus.mwmask[3:0] << off_d;
      // Access size comes from the mask for stores and from the load type for loads.
      half_d  = bus.mwen ? (bus.mwmask[3:0] == 4'b0011)
                         : (bus.mrtype == 3'd1 || bus.mrtype == 3'd4);
      word_d  = bus.mwen ? (bus.mwmask[3:0] == 4'b1111)
                         : (bus.mrtype == 3'd2);
      mis_d   = (half_d && off_d == 2'd3) || (word_d && off_d != 2'd0);
      hs      = bus.s_valid & bus.s_ready;
      cnt_d   = cnt_q + CNT_W'(1);

      ld_shift = bus.rsp_rdata >> {off_q, 3'b000};
      case (rtype_q)
         3'd0:    ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'd1:    ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
         3'd3:    ld_ext = {24'd0, ld_shift[7:0]};
         3'd4:    ld_ext = {16'd0, ld_shift[15:0]};
         default: ld_ext = ld_shift;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         rtype_q <= 3'd0;
         wdata_q <= 32'd0;
         wstrb_q <= 4'd0;
         off_q   <= 2'd0;
         cnt_q   <= '0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hs) begin
                  addr_q  <= {bus.addr[ADDR_W-1:2], 2'b00};
                  wen_q   <= bus.mwen;
                  rtype_q <= bus.mrtype;
                  wdata_q <= wdata_d;
                  wstrb_q <= wstrb_d;
                  off_q   <= off_d;
                  rdata_q <= 32'd0;
                  err_q   <= 1'b0;
                  if (!bus.mvalid) begin
                     state_q <= DONE;
                  end else if (mis_d) begin
                     err_q   <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     state_q <= REQ;
                  end
               end
            end
            REQ: begin
               if (bus.req_ready) begin
                  cnt_q   <= '0;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               // A response arriving on the deadline cycle still wins over the timeout.
               if (bus.rsp_valid) begin
                  rdata_q <= wen_q ? 32'd0 : ld_ext;
                  err_q   <= bus.rsp_err;
                  state_q <= DONE;
               end else if (TIMEOUT != 0 && cnt_d == CNT_W'(TIMEOUT)) begin
                  rdata_q <= 32'd0;
                  err_q   <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            DONE: begin
               if (bus.m_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.s_ready   = (state_q == IDLE) & ~rst;
   assign bus.req_valid = (state_q == REQ) & ~rst;
   assign bus.req_wen   = wen_q;
   assign bus.req_addr  = addr_q;
   assign bus.req_wdata = wdata_q;
   assign bus.req_wstrb = wstrb_q;
   assign bus.m_valid   = (state_q == DONE) & ~rst;
   assign bus.m_rdata   = rdata_q;
   assign bus.m_err     = err_q;
endmodule
